tx_channel: RTL
===============

TX_CHANNEL -- requirements
Module: tx_channel

Interface
REQ-001 SHALL have parameter N_TAPS, default 4, number of channel FIR taps.
REQ-002 SHALL have parameter COEF_BW, default 8, tap width in S(8,6).
REQ-003 SHALL have parameter OUT_BW, default 11, output sample width in S(11,8).
REQ-004 SHALL have parameter PRBS_SEED, default 9'h1FF, LFSR reset value.
REQ-005 SHALL have port clockdsp, input, 1, the only clock.
REQ-006 SHALL have port soft_reset_n, input, 1, reset (synchronous, active-low).
REQ-007 SHALL have port i_en, input, 1, symbol strobe: one symbol produced per cycle with i_en=1.
REQ-008 SHALL have port i_mode, input, 2, source select: 00 PRBS, 01 constant +1, 10 impulse, 11 zero.
REQ-009 SHALL have ports i_coef_we (1), i_coef_addr (2) and i_coef_data (COEF_BW), all inputs, shadow tap write.
REQ-010 SHALL have port i_coef_commit, input, 1, copy all shadow taps to the active taps.
REQ-011 SHALL have port i_sat_clr, input, 1, clear the saturation counter.
REQ-012 SHALL have port o_data, output, OUT_BW, channel sample that feeds the DSP input.
REQ-013 SHALL have port o_valid, output, 1, marks a new o_data.
REQ-014 SHALL have port o_sat_count, output, 16, saturating count of clipped samples.

Function
REQ-015 SHALL use a PRBS9 LFSR s[8:0], x^9+x^5+1: on i_en, symbol bit = s[8]; then s <= {s[7:0], s[8]^s[4]}.
REQ-016 SHALL advance the LFSR only on i_en in mode 00; other modes hold the LFSR.
REQ-017 SHALL map symbols as ternary: PRBS bit 0 -> +1, bit 1 -> -1; mode 01 -> +1; mode 11 -> 0.
REQ-018 SHALL in mode 10 emit +1 on the first i_en after entering the mode or after reset, then 0 until the mode changes away and back.
REQ-019 SHALL shift each new symbol into delay line x[0..N_TAPS-1] on i_en; x[k] <= x[k-1].
REQ-020 SHALL form sum = sum over k of x[k]*tap[k] in S(10,6), using add/subtract/skip only (no multipliers), and register it one cycle after the shift.
REQ-021 SHALL register o_data = sum<<2 on the next cycle, saturated to [-1024, 1023].
REQ-022 SHALL give o_data and o_valid a latency of 2 cycles after the i_en cycle; o_valid = i_en delayed 2; o_data holds while o_valid=0.
REQ-023 SHALL increment o_sat_count on every o_valid sample that was clipped, stop at 16'hFFFF, and clear on i_sat_clr; if clear and increment happen together, clear wins.
REQ-024 SHALL write a shadow tap on i_coef_we with no effect on the output until commit.
REQ-025 SHALL on i_coef_commit load the active taps at that edge; the sum computed in that cycle uses the old taps.
REQ-026 SHALL on simultaneous i_coef_we and i_coef_commit commit the shadow value including the new write.
REQ-027 SHALL leave the delay line contents unchanged when i_mode changes; only new symbols reflect the new mode.

Reset
REQ-028 SHALL on soft_reset_n=0 set: LFSR=PRBS_SEED; delay line=0; sum register=0; o_data=0; o_valid=0; o_sat_count=0; impulse armed.
REQ-029 SHALL reset shadow and active taps to {64,0,0,0} (pass-through, 1.0); a reset mid-stream drops in-flight samples.

Structure
REQ-030 SHALL place the shared package constants in dsp_pkg: mode encodings, PRBS9 polynomial and seed, S(8,6) unity tap (64), output saturation limits.
REQ-031 SHALL be implemented as one sub-module, prbs9_gen (LFSR plus enable), instantiated in tx_channel.

Verification
REQ-032 SHALL cover: reset, mode 00, default taps, i_en held high -> first 9 o_valid samples are -256, and the 10th is +256.
REQ-033 SHALL cover: commit taps {64,32,-16,0}, mode 10, i_en high -> o_data sequence 256, 128, -64, 0, 0…, with the first sample 2 cycles after the first i_en.
REQ-034 SHALL cover: taps all 127, mode 01 -> o_data 1023 once the line is full, and o_sat_count increments on each sample; then i_sat_clr -> o_sat_count=0.
REQ-035 SHALL cover: write tap0=-64 with no commit -> output unchanged; then commit -> samples from the next sum on are negated.
REQ-036 SHALL cover: i_en toggled 1,0,0,1 -> o_valid 1,0,0,1 delayed by 2, and o_data held during the gaps.
REQ-037 SHALL cover: soft_reset_n low for 1 cycle mid-stream -> all outputs 0, taps {64,0,0,0}, and the PRBS restarts from the seed.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP constants for the transmit channel: source modes, PRBS9 definition,
// S(8,6) unity tap and output saturation limits.
package dsp_pkg;

    localparam logic [1:0] MODE_PRBS    = 2'b00;
    localparam logic [1:0] MODE_CONST   = 2'b01;
    localparam logic [1:0] MODE_IMPULSE = 2'b10;
    localparam logic [1:0] MODE_ZERO    = 2'b11;

    // x^9 + x^5 + 1: feedback is s[8] ^ s[4]
    localparam int         PRBS9_FB_TAP = 4;
    localparam logic [8:0] PRBS9_SEED   = 9'h1FF;

    localparam int TAP_UNITY   = 64;
    localparam int OUT_SAT_MAX = 1023;
    localparam int OUT_SAT_MIN = -1024;

    typedef logic signed [1:0] sym_t;
    localparam sym_t SYM_POS  = 2'sb01;
    localparam sym_t SYM_ZERO = 2'sb00;
    localparam sym_t SYM_NEG  = 2'sb11;

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 source: presents s[8] as the current bit and steps the LFSR when enabled.
module prbs9_gen
    import dsp_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED
) (
    input  logic clockdsp,
    input  logic soft_reset_n,
    input  logic en,
    output logic prbs_bit
);

    logic [8:0] state;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clockdsp) begin
        if (!soft_reset_n) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[7:0], state[8] ^ state[PRBS9_FB_TAP]};
        end
    end

    assign prbs_bit = state[8];

endmodule

// File: rtl/tx_channel.sv
// Ternary symbol source feeding a multiplier-free channel FIR with double-buffered
// taps, saturating output stage and clipped-sample counter.
module tx_channel
    import dsp_pkg::*;
#(
    parameter int         N_TAPS    = 4,
    parameter int         COEF_BW   = 8,
    parameter int         OUT_BW    = 11,
    parameter logic [8:0] PRBS_SEED = PRBS9_SEED
) (
    input  logic               clockdsp,
    input  logic               soft_reset_n,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic               i_coef_we,
    input  logic [1:0]         i_coef_addr,
    input  logic [COEF_BW-1:0] i_coef_data,
    input  logic               i_coef_commit,
    input  logic               i_sat_clr,
    output logic [OUT_BW-1:0]  o_data,
    output logic               o_valid,
    output logic [15:0]        o_sat_count
);

    localparam int SUM_BW = COEF_BW + $clog2(N_TAPS);
    localparam int SCL_BW = SUM_BW + 2;
    localparam logic signed [SCL_BW-1:0] SAT_HI = SCL_BW'(OUT_SAT_MAX);
    localparam logic signed [SCL_BW-1:0] SAT_LO = SCL_BW'(OUT_SAT_MIN);

    logic signed [COEF_BW-1:0] shadow_tap  [N_TAPS];
    logic signed [COEF_BW-1:0] shadow_next [N_TAPS];
    logic signed [COEF_BW-1:0] active_tap  [N_TAPS];
    sym_t                      x           [N_TAPS];
    sym_t                      x_next      [N_TAPS];

    logic                      prbs_bit;
    logic                      impulse_armed;
    sym_t                      sym;
    logic signed [SUM_BW-1:0]  sum_next;
    logic signed [SUM_BW-1:0]  sum_q;
    logic signed [SCL_BW-1:0]  scaled;
    logic                      clip_hi;
    logic                      clip_lo;
    logic [OUT_BW-1:0]         sat_data;
    logic                      valid_d1;

    prbs9_gen #(.SEED(PRBS_SEED)) u_prbs (
        .clockdsp     (clockdsp),
        .soft_reset_n (soft_reset_n),
        .en           (i_en && (i_mode == MODE_PRBS)),
        .prbs_bit     (prbs_bit)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sym = SYM_ZERO;
        unique case (i_mode)
            MODE_PRBS:    sym = prbs_bit ? SYM_NEG : SYM_POS;
            MODE_CONST:   sym = SYM_POS;
            MODE_IMPULSE: sym = impulse_armed ? SYM_POS : SYM_ZERO;
            default:      sym = SYM_ZERO;
        endcase
    end

    // A simultaneous write and commit must land the new write in the active set.
    always_comb begin
        shadow_next = shadow_tap;
        if (i_coef_we) shadow_next[i_coef_addr] = i_coef_data;
    end

    always_comb begin
        x_next[0] = sym;
        for (int k = 1; k < N_TAPS; k++) x_next[k] = x[k-1];
    end

    // Ternary symbols reduce each product to add, subtract or skip.
    always_comb begin
        sum_next = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (x_next[k] == SYM_POS)      sum_next = sum_next + SUM_BW'(active_tap[k]);
            else if (x_next[k] == SYM_NEG) sum_next = sum_next - SUM_BW'(active_tap[k]);
        end
    end

    assign scaled   = {sum_q, 2'b00};
    assign clip_hi  = scaled > SAT_HI;
    assign clip_lo  = scaled < SAT_LO;
    assign sat_data = clip_hi ? OUT_BW'(OUT_SAT_MAX) :
                      clip_lo ? OUT_BW'(OUT_SAT_MIN) : scaled[OUT_BW-1:0];

    // NOTE: the tap arrays are reset because the channel must start as a known pass-through.
    always_ff @(posedge clockdsp) begin
        if (!soft_reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_tap[k] <= (k == 0) ? COEF_BW'(TAP_UNITY) : '0;
                active_tap[k] <= (k == 0) ? COEF_BW'(TAP_UNITY) : '0;
            end
        end else begin
            shadow_tap <= shadow_next;
            if (i_coef_commit) active_tap <= shadow_next;
        end
    end

    always_ff @(posedge clockdsp) begin
        if (!soft_reset_n) begin
            for (int k = 0; k < N_TAPS; k++) x[k] <= SYM_ZERO;
            sum_q         <= '0;
            impulse_armed <= 1'b1;
        end else begin
            if (i_en) begin
                x     <= x_next;
                sum_q <= sum_next;
            end
            if (i_mode != MODE_IMPULSE) impulse_armed <= 1'b1;
            else if (i_en)              impulse_armed <= 1'b0;
        end
    end

    always_ff @(posedge clockdsp) begin
        if (!soft_reset_n) begin
            valid_d1    <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_sat_count <= '0;
        end else begin
            valid_d1 <= i_en;
            o_valid  <= valid_d1;
            if (valid_d1) o_data <= sat_data;
            if (i_sat_clr) begin
                o_sat_count <= '0;
            end else if (valid_d1 && (clip_hi || clip_lo) && (o_sat_count != 16'hFFFF)) begin
                o_sat_count <= o_sat_count + 16'd1;
            end
        end
    end

endmodule
